// File: rtl/des_pkg.sv
// DES constants shared by the round controller: permutation tables, key shift
// schedule, S-box contents, controller state encoding and the permutation helpers.
package des_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Tables use DES numbering: entry j names the 1-based source bit, bit 1 = MSB.
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // One 256-bit word per S-box: rows 0..3 of 16 nibbles, column 0 in the top nibble.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] ip(input logic [63:0] b);
      logic [63:0] o;
      o = '0;
      for (int j = 0; j < 64; j++) o[6'(63 - j)] = b[6'(64 - IP_T[j])];
      return o;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] b);
      logic [63:0] o;
      o = '0;
      for (int j = 0; j < 64; j++) o[6'(63 - j)] = b[6'(64 - FP_T[j])];
      return o;
   endfunction

   function automatic logic [47:0] expand(input logic [31:0] b);
      logic [47:0] o;
      o = '0;
      for (int j = 0; j < 48; j++) o[6'(47 - j)] = b[5'(32 - E_T[j])];
      return o;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] b);
      logic [31:0] o;
      o = '0;
      for (int j = 0; j < 32; j++) o[5'(31 - j)] = b[5'(32 - P_T[j])];
      return o;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] b);
      logic [55:0] o;
      o = '0;
      for (int j = 0; j < 56; j++) o[6'(55 - j)] = b[6'(64 - PC1_T[j])];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] b);
      logic [47:0] o;
      o = '0;
      for (int j = 0; j < 48; j++) o[6'(47 - j)] = b[6'(56 - PC2_T[j])];
      return o;
   endfunction

endpackage

// File: rtl/SBoxArray.sv
// Combinational bank of the eight DES S-boxes: 48-bit E(R)^K in, 32-bit result out.
module SBoxArray
   import des_pkg::*;
(
   input  logic [47:0] xor_result,
   output logic [31:0] sbox_out
);

   for (genvar i = 0; i < 8; i++) begin : g_sbox
      localparam logic [255:0] TAB = SBOX[i];
      logic [5:0] six;
      logic [5:0] idx;
      assign six = xor_result[47-6*i -: 6];
      assign idx = {six[5], six[0], six[4:1]};
      // Nibble idx sits at bit 255-4*idx, which is exactly {~idx, 2'b11}.
      assign sbox_out[31-4*i -: 4] = TAB[{~idx, 2'b11} -: 4];
   end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES controller, one Feistel round per clock with on-the-fly key schedule.
// Define DES_DECRYPT_EN to add the in_decrypt port and the reverse key schedule.
module des_round_ctrl
   import des_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   input  logic [63:0] in_key,
`ifdef DES_DECRYPT_EN
   input  logic        in_decrypt,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block,
   output logic        busy
);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] l, r, r_nx, sb;
   logic [27:0] c, d, c_nx, d_nx;
   logic [47:0] ki, xr;
   int          sh;
`ifdef DES_DECRYPT_EN
   logic        dec;
`endif

   function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
      return (n == 2) ? {x[25:0], x[27:26]} : (n == 1) ? {x[26:0], x[27]} : x;
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
      return (n == 2) ? {x[1:0], x[27:2]} : (n == 1) ? {x[0], x[27:1]} : x;
   endfunction

   always_comb begin
      sh   = SHIFT[cnt];
      c_nx = rotl(c, sh);
      d_nx = rotl(d, sh);
`ifdef DES_DECRYPT_EN
      // Decrypt walks the schedule backwards; K16 comes straight from C0/D0.
      if (dec) begin
         c_nx = (cnt == '0) ? c : rotr(c, sh);
         d_nx = (cnt == '0) ? d : rotr(d, sh);
      end
`endif
   end

   assign ki   = pc2({c_nx, d_nx});
   assign xr   = expand(r) ^ ki;
   assign r_nx = l ^ perm_p(sb);

   SBoxArray u_sbox (
      .xor_result (xr),
      .sbox_out   (sb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_block <= '0;
         cnt       <= '0;
         l         <= '0;
         r         <= '0;
         c         <= '0;
         d         <= '0;
`ifdef DES_DECRYPT_EN
         dec       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               {l, r}   <= ip(in_block);
               {c, d}   <= pc1(in_key);
`ifdef DES_DECRYPT_EN
               dec      <= in_decrypt;
`endif
               in_ready <= 1'b0;
               busy     <= 1'b1;
               state    <= LOAD;
            end
            LOAD: begin
               cnt   <= '0;
               state <= ROUND;
            end
            ROUND: begin
               l <= r;
               r <= r_nx;
               c <= c_nx;
               d <= d_nx;
               if (cnt == 4'(NUM_ROUNDS - 1)) begin
                  // Counter parks on the last round; LOAD clears it for the next block.
                  out_block <= fp({r_nx, r});
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed and randomized bench for des_round_ctrl against a whole-block DES model.
module tb_des_round_ctrl;
   import des_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_decrypt = 1'b0;
   logic        in_ready, out_valid, busy;
   logic [63:0] in_block = '0, in_key = '0, out_block;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   des_round_ctrl #(.NUM_ROUNDS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .in_key     (in_key),
`ifdef DES_DECRYPT_EN
      .in_decrypt (in_decrypt),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_block  (out_block),
      .busy       (busy)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [27:0] rot28(input logic [27:0] x, input int n);
      logic [55:0] y;
      y = {x, x} << n;
      return y[55:28];
   endfunction

   function automatic logic [31:0] sbox_ref(input logic [47:0] x);
      logic [31:0]  o;
      logic [5:0]   six;
      logic [255:0] t, v;
      int           n;
      o = '0;
      for (int s = 0; s < 8; s++) begin
         six = x[47:42];
         x   = x << 6;
         n   = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
         t   = SBOX[s];
         v   = t >> (4 * (63 - n));
         o   = {o[27:0], v[3:0]};
      end
      return o;
   endfunction

   // Whole-block DES: all 16 subkeys from cumulative rotations, then the Feistel loop.
   function automatic logic [63:0] des_ref(input logic [63:0] key, blk, input logic dec);
      logic [55:0] cd;
      logic [47:0] ks [16];
      logic [31:0] lh, rh, t;
      logic [63:0] x;
      int          tot;
      cd  = pc1(key);
      tot = 0;
      for (int i = 0; i < 16; i++) begin
         tot  += SHIFT[i];
         ks[i] = pc2({rot28(cd[55:28], tot), rot28(cd[27:0], tot)});
      end
      x  = ip(blk);
      lh = x[63:32];
      rh = x[31:0];
      for (int i = 0; i < 16; i++) begin
         t  = lh ^ perm_p(sbox_ref(expand(rh) ^ ks[dec ? 15 - i : i]));
         lh = rh;
         rh = t;
      end
      return fp({rh, lh});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a block for one cycle; returns at the negedge after the accepting edge.
   task automatic start_block(input logic [63:0] key, input logic [63:0] blk, input logic dec);
      int t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      chk("start_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_key = key; in_block = blk; in_decrypt = dec;
      @(negedge clk);
      in_valid = 1'b0; in_key = 'x; in_block = 'x; in_decrypt = 1'b0;
      chk("in_ready_drop", 64'(in_ready), 64'd0);
      chk("busy_load", 64'(busy), 64'd1);
   endtask

   task automatic wait_result(input int start, output int lat);
      lat = start;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_drop", 64'(out_valid), 64'd0);
      chk("in_ready_back", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int lat, seen, np;
      int pulse [3];
      logic [63:0] k, b, exp;
      logic dsel;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_block", out_block, 64'd0);

      // Standard vector
      start_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
      wait_result(1, lat);
      chk("vec1_latency", 64'(lat), 64'd18);
      chk("vec1_block", out_block, 64'h85E813540F0AB405);
      chk("vec1_busy_done", 64'(busy), 64'd0);
      release_result();

      // Second vector, input pulse mid-round, then back-pressure
      start_block(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0);
      repeat (4) @(negedge clk);
      in_valid = 1'b1; in_key = {$urandom, $urandom}; in_block = {$urandom, $urandom};
      repeat (2) @(negedge clk);
      in_valid = 1'b0; in_key = 'x; in_block = 'x;
      wait_result(7, lat);
      chk("vec2_latency", 64'(lat), 64'd18);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_out_block", out_block, 64'h0000000000000000);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      release_result();

      // Asynchronous reset in the middle of a block
      start_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_out_block", out_block, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin @(negedge clk); seen |= int'(out_valid); end
      chk("mrst_no_stale", 64'(seen), 64'd0);
      start_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
      wait_result(1, lat);
      chk("mrst_latency", 64'(lat), 64'd18);
      chk("mrst_block", out_block, 64'h85E813540F0AB405);
      release_result();

      // Random blocks against the model
      for (int i = 0; i < 8; i++) begin
         k = {$urandom, $urandom};
         b = {$urandom, $urandom};
`ifdef DES_DECRYPT_EN
         dsel = 1'($urandom_range(0, 1));
`else
         dsel = 1'b0;
`endif
         exp = des_ref(k, b, dsel);
         start_block(k, b, dsel);
         wait_result(1, lat);
         chk("rnd_latency", 64'(lat), 64'd18);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rnd_block", out_block, exp);
         release_result();
      end

      // Back-to-back with both handshakes tied high
      k = {$urandom, $urandom};
      b = {$urandom, $urandom};
      exp = des_ref(k, b, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1; in_key = k; in_block = b; in_decrypt = 1'b0;
      np = 0;
      for (int t = 0; t < 120 && np < 3; t++) begin
         @(negedge clk);
         if (out_valid) begin
            pulse[np] = t;
            np++;
            chk("b2b_block", out_block, exp);
         end
      end
      in_valid = 1'b0;
      chk("b2b_pulses", 64'(np), 64'd3);
      if (np == 3) begin
         chk("b2b_period1", 64'(pulse[1] - pulse[0]), 64'd19);
         chk("b2b_period2", 64'(pulse[2] - pulse[1]), 64'd19);
      end
      repeat (25) @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_idle", 64'(in_ready), 64'd1);

`ifdef DES_DECRYPT_EN
      start_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1);
      wait_result(1, lat);
      chk("dec_latency", 64'(lat), 64'd18);
      chk("dec_block", out_block, 64'h0123456789ABCDEF);
      release_result();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
